// File: rtl/font_text_line_renderer_pkg.sv
// Font sheet geometry and shared helpers for the text line renderer.
// The sheet is FONT_NUM_COL x FONT_NUM_ROW glyphs, each FONT_WIDTH_CNT x FONT_HEIGHT_CNT px,
// laid out row-major in the font ROM.
package font_text_line_renderer_pkg;

   localparam int unsigned FONT_WIDTH_CNT  = 8;
   localparam int unsigned FONT_HEIGHT_CNT = 8;
   localparam int unsigned FONT_NUM_COL    = 8;
   localparam int unsigned FONT_NUM_ROW    = 8;
   localparam int unsigned FONT_W_LOG2     = $clog2(FONT_WIDTH_CNT);
   localparam int unsigned FONT_H_LOG2     = $clog2(FONT_HEIGHT_CNT);
   localparam int unsigned BLANK_CHAR      = 0;

   // Scale shift 3 is not supported by the sheet sizing, so it behaves as 2.
   function automatic logic [1:0] eff_shift(input logic [1:0] s);
      return (s == 2'd3) ? 2'd2 : s;
   endfunction

endpackage

// File: rtl/font_text_line_renderer_buf.sv
// Character buffer: MAX_CHARS x ALPHABET_BITS_N register file.
// Ports: clk, rst (async, active-low), wr_en/wr_idx/wr_char synchronous write,
//        clear (loads BLANK_CHAR everywhere, wins over wr_en), rd_idx -> rd_char_c
//        asynchronous read.
module font_text_line_renderer_buf
   import font_text_line_renderer_pkg::*;
#(
   parameter int unsigned ALPHABET_BITS_N = 6,
   parameter int unsigned MAX_CHARS       = 16,
   parameter int unsigned IDX_BITS_N      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [IDX_BITS_N-1:0]      wr_idx,
   input  logic [ALPHABET_BITS_N-1:0] wr_char,
   input  logic                       clear,
   input  logic [IDX_BITS_N-1:0]      rd_idx,
   output logic [ALPHABET_BITS_N-1:0] rd_char_c
);

   logic [ALPHABET_BITS_N-1:0] mem [MAX_CHARS];

   // Storage with clear taking priority over a single-slot write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(MAX_CHARS); i++) mem[i] <= ALPHABET_BITS_N'(BLANK_CHAR);
      end else if (clear) begin
         for (int i = 0; i < int'(MAX_CHARS); i++) mem[i] <= ALPHABET_BITS_N'(BLANK_CHAR);
      end else if (wr_en) begin
         mem[wr_idx] <= wr_char;
      end
   end

   assign rd_char_c = mem[rd_idx];

endmodule

// File: rtl/font_text_line_renderer.sv
// Text line renderer: maps VGA counters to font ROM pixel addresses for a line of
// glyphs at a programmable half-res origin, with 1/2/4x scale and optional blink.
// Ports: clk, rst (async, active-low); h_cnt/v_cnt VGA counters; pos_h_cnt/pos_v_cnt
//        origin; scale_shift; str_len; wr_en/wr_idx/wr_char/clear buffer write;
//        frame_tick/blink_en blink control; pixel_addr/addr_valid (2 cycles after the
//        counters); px_valid = addr_valid delayed by ROM_LATENCY.
module font_text_line_renderer
   import font_text_line_renderer_pkg::*;
#(
   parameter int unsigned CNT_BITS_N      = 10,
   parameter int unsigned PX_ADDR_BITS_N  = 16,
   parameter int unsigned ALPHABET_BITS_N = 6,
   parameter int unsigned MAX_CHARS       = 16,
   parameter int unsigned IDX_BITS_N      = 4,
   parameter int unsigned ROM_LATENCY     = 1,
   parameter int unsigned BLINK_FRAMES    = 30
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CNT_BITS_N-1:0]      h_cnt,
   input  logic [CNT_BITS_N-1:0]      v_cnt,
   input  logic [CNT_BITS_N-1:0]      pos_h_cnt,
   input  logic [CNT_BITS_N-1:0]      pos_v_cnt,
   input  logic [1:0]                 scale_shift,
   input  logic [IDX_BITS_N:0]        str_len,
   input  logic                       wr_en,
   input  logic [IDX_BITS_N-1:0]      wr_idx,
   input  logic [ALPHABET_BITS_N-1:0] wr_char,
   input  logic                       clear,
   input  logic                       frame_tick,
   input  logic                       blink_en,
   output logic [PX_ADDR_BITS_N-1:0]  pixel_addr,
   output logic                       addr_valid,
   output logic                       px_valid
);

   // Wide enough for MAX_CHARS * W << 2 and any counter value, so compares never wrap.
   localparam int unsigned EXT_N        = CNT_BITS_N + IDX_BITS_N + FONT_W_LOG2 + 4;
   localparam int unsigned BLINK_BITS_N = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   // ---------------- stage 0: box hit test and glyph-local coordinates
   logic [CNT_BITS_N-1:0]  hx, hy, rx, ry, rx_s;
   logic [1:0]             s_eff;
   logic [IDX_BITS_N:0]    len_c;
   logic [EXT_N-1:0]       box_w, box_h;
   logic                   hit_d;
   logic [IDX_BITS_N-1:0]  slot_d;
   logic [FONT_W_LOG2-1:0] gx_d;
   logic [FONT_H_LOG2-1:0] gy_d;

   always_comb begin
      hx     = h_cnt >> 1;
      hy     = v_cnt >> 1;
      rx     = hx - pos_h_cnt;
      ry     = hy - pos_v_cnt;
      s_eff  = eff_shift(scale_shift);
      len_c  = (str_len > (IDX_BITS_N+1)'(MAX_CHARS)) ? (IDX_BITS_N+1)'(MAX_CHARS) : str_len;
      box_w  = (EXT_N'(len_c) << FONT_W_LOG2) << s_eff;
      box_h  = EXT_N'(FONT_HEIGHT_CNT) << s_eff;
      hit_d  = (hx >= pos_h_cnt) && (hy >= pos_v_cnt) &&
               (EXT_N'(rx) < box_w) && (EXT_N'(ry) < box_h);
      rx_s   = rx >> s_eff;
      slot_d = IDX_BITS_N'(rx_s >> FONT_W_LOG2);
      gx_d   = FONT_W_LOG2'(rx_s);
      gy_d   = FONT_H_LOG2'(ry >> s_eff);
   end

   logic                   hit_q;
   logic [IDX_BITS_N-1:0]  slot_q;
   logic [FONT_W_LOG2-1:0] gx_q;
   logic [FONT_H_LOG2-1:0] gy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q  <= 1'b0;
         slot_q <= '0;
         gx_q   <= '0;
         gy_q   <= '0;
      end else begin
         hit_q  <= hit_d;
         slot_q <= slot_d;
         gx_q   <= gx_d;
         gy_q   <= gy_d;
      end
   end

   // ---------------- character buffer
   logic [ALPHABET_BITS_N-1:0] glyph;

   font_text_line_renderer_buf #(
      .ALPHABET_BITS_N (ALPHABET_BITS_N),
      .MAX_CHARS       (MAX_CHARS),
      .IDX_BITS_N      (IDX_BITS_N)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_char   (wr_char),
      .clear     (clear),
      .rd_idx    (slot_q),
      .rd_char_c (glyph)
   );

   // ---------------- blink: phase toggles every BLINK_FRAMES ticks, regardless of blink_en
   logic [BLINK_BITS_N-1:0] blink_cnt;
   logic                    blink_phase;
   logic                    blank_phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt == BLINK_BITS_N'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt + BLINK_BITS_N'(1);
         end
      end
   end

   assign blank_phase = blink_en & blink_phase;

   // ---------------- stage 1: glyph lookup to sheet address
   logic [PX_ADDR_BITS_N-1:0] glyph_col, glyph_row, addr_d;
   logic                      valid_d;

   always_comb begin
      glyph_col = PX_ADDR_BITS_N'(32'(glyph) % FONT_NUM_COL);
      glyph_row = PX_ADDR_BITS_N'((32'(glyph) / FONT_NUM_COL) % FONT_NUM_ROW);
      addr_d    = PX_ADDR_BITS_N'(gx_q)
                + PX_ADDR_BITS_N'(FONT_WIDTH_CNT) * glyph_col
                + PX_ADDR_BITS_N'(FONT_WIDTH_CNT * FONT_NUM_COL)
                  * (PX_ADDR_BITS_N'(gy_q) + PX_ADDR_BITS_N'(FONT_HEIGHT_CNT) * glyph_row);
      valid_d   = hit_q & ~blank_phase;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixel_addr <= '0;
         addr_valid <= 1'b0;
      end else begin
         pixel_addr <= valid_d ? addr_d : '0;
         addr_valid <= valid_d;
      end
   end

   // ---------------- px_valid: addr_valid aligned to font ROM read data
   generate
      if (ROM_LATENCY == 0) begin : g_no_lat
         assign px_valid = addr_valid;
      end else begin : g_lat
         logic [ROM_LATENCY-1:0] vld_sr;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) vld_sr <= '0;
            else      vld_sr <= ROM_LATENCY'({vld_sr, addr_valid});
         end
         assign px_valid = vld_sr[ROM_LATENCY-1];
      end
   endgenerate

endmodule

// File: tb/tb_font_text_line_renderer.sv
// Bench for font_text_line_renderer (ROM_LATENCY=2, BLINK_FRAMES=2): directed cases
// followed by a randomized sweep, all compared against a behavioural line model.
module tb_font_text_line_renderer;

   localparam int ROM_LAT = 2;
   localparam int BF      = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  h_cnt, v_cnt, pos_h_cnt, pos_v_cnt;
   logic [1:0]  scale_shift;
   logic [4:0]  str_len;
   logic        wr_en, clear, frame_tick, blink_en;
   logic [3:0]  wr_idx;
   logic [5:0]  wr_char;
   logic [15:0] pixel_addr;
   logic        addr_valid, px_valid;

   font_text_line_renderer #(.ROM_LATENCY(ROM_LAT), .BLINK_FRAMES(BF)) dut (
      .clk         (clk),
      .rst         (rst),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .pos_h_cnt   (pos_h_cnt),
      .pos_v_cnt   (pos_v_cnt),
      .scale_shift (scale_shift),
      .str_len     (str_len),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_char     (wr_char),
      .clear       (clear),
      .frame_tick  (frame_tick),
      .blink_en    (blink_en),
      .pixel_addr  (pixel_addr),
      .addr_valid  (addr_valid),
      .px_valid    (px_valid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference state
   int bufm [16];
   int ticks;
   int n_posh, n_posv, n_scale, n_len, n_blink;
   bit q_v [$];
   int q_a [$];
   bit vh  [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // Expected output for one screen pixel, from the line geometry directly.
   function automatic void model(input int h, input int v, output bit val, output int addr);
      int hx, hy, s, len, rx, ry, slot, gx, gy, g, cw;
      val  = 1'b0;
      addr = 0;
      hx   = h / 2;
      hy   = v / 2;
      s    = (int'(scale_shift) == 3) ? 2 : int'(scale_shift);
      len  = (int'(str_len) > 16) ? 16 : int'(str_len);
      cw   = 8 * (1 << s);
      if (hx < int'(pos_h_cnt) || hy < int'(pos_v_cnt)) return;
      rx = hx - int'(pos_h_cnt);
      ry = hy - int'(pos_v_cnt);
      if (rx >= len * cw || ry >= cw) return;
      if (blink_en && ((ticks / BF) % 2 == 1)) return;
      slot = rx / cw;
      gx   = (rx / (1 << s)) % 8;
      gy   = (ry / (1 << s)) % 8;
      g    = bufm[slot];
      val  = 1'b1;
      addr = gx + 8 * (g % 8) + 64 * (gy + 8 * ((g / 8) % 8));
   endfunction

   // One clock: check the pixel from two cycles ago, then drive this cycle's inputs.
   task automatic cyc(input int h, input int v, input bit we = 1'b0, input int wi = 0,
                      input int wc = 0, input bit clr = 1'b0, input bit tick = 1'b0);
      bit ev;
      int ea;
      @(posedge clk);
      #1;
      if (q_v.size() >= 2) begin
         ev = q_v.pop_front();
         ea = q_a.pop_front();
         chk("addr_valid", 32'(addr_valid), 32'(ev));
         chk("pixel_addr", 32'(pixel_addr), 32'(ea));
         vh.push_back(ev);
         if (vh.size() == ROM_LAT + 1) begin
            chk("px_valid", 32'(px_valid), 32'(vh[0]));
            void'(vh.pop_front());
         end
      end
      h_cnt       = 10'(h);
      v_cnt       = 10'(v);
      pos_h_cnt   = 10'(n_posh);
      pos_v_cnt   = 10'(n_posv);
      scale_shift = 2'(n_scale);
      str_len     = 5'(n_len);
      blink_en    = n_blink[0];
      wr_en       = we;
      wr_idx      = 4'(wi);
      wr_char     = 6'(wc);
      clear       = clr;
      frame_tick  = tick;
      if (clr) begin
         for (int i = 0; i < 16; i++) bufm[i] = 0;
      end else if (we) begin
         bufm[wi] = wc;
      end
      if (tick) ticks++;
      model(h, v, ev, ea);
      q_v.push_back(ev);
      q_a.push_back(ea);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0);
   endtask

   task automatic flush_model();
      q_v.delete();
      q_a.delete();
      vh.delete();
      for (int i = 0; i < 16; i++) bufm[i] = 0;
      ticks = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      h_cnt = '0; v_cnt = '0; pos_h_cnt = '0; pos_v_cnt = '0;
      scale_shift = '0; str_len = '0; wr_en = 1'b0; wr_idx = '0; wr_char = '0;
      clear = 1'b0; frame_tick = 1'b0; blink_en = 1'b0;
      n_posh = 10; n_posv = 20; n_scale = 0; n_len = 3; n_blink = 0;
      flush_model();
      #22;
      chk("rst_addr", 32'(pixel_addr), 0);
      chk("rst_valid", 32'(addr_valid), 0);
      chk("rst_pxv", 32'(px_valid), 0);
      rst = 1'b1;

      // load "A B C" = codes 1,2,3
      cyc(0, 0, 1'b1, 0, 1);
      cyc(0, 0, 1'b1, 1, 2);
      cyc(0, 0, 1'b1, 2, 3);
      idle(2);

      // basic hit at slot 1, gx=1, gy=2; valid appears two cycles after the sample
      cyc(38, 44);
      chk("lat_before", 32'(addr_valid), 0);
      cyc(38, 44);
      chk("lat_one", 32'(addr_valid), 0);
      cyc(38, 44);
      chk("basic_valid", 32'(addr_valid), 1);
      chk("basic_addr", 32'(pixel_addr), 145);

      // scale 2x: hx=pos+17 -> slot 1, gx 0, gy 1; hx=pos+48 is just past the box
      n_scale = 1;
      cyc(54, 44); cyc(54, 44); cyc(54, 44);
      chk("s1_addr", 32'(pixel_addr), 80);
      cyc(116, 44); cyc(116, 44); cyc(116, 44);
      chk("s1_edge_valid", 32'(addr_valid), 0);
      chk("s1_edge_addr", 32'(pixel_addr), 0);

      // px_valid across the right box edge (checked every cycle by cyc)
      for (int x = 40; x < 56; x++) cyc(2 * (10 + x), 44);
      n_scale = 0;
      idle(2);

      // reset mid-line
      cyc(38, 44); cyc(38, 44); cyc(38, 44);
      chk("pre_rst_valid", 32'(addr_valid), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_addr", 32'(pixel_addr), 0);
      chk("midrst_valid", 32'(addr_valid), 0);
      chk("midrst_pxv", 32'(px_valid), 0);
      #2;
      rst = 1'b1;
      flush_model();
      cyc(38, 44); cyc(38, 44); cyc(38, 44);
      chk("blank_after_rst", 32'(pixel_addr), 129);

      // clear beats a same-cycle write to slot 0
      cyc(0, 0, 1'b1, 0, 5, 1'b1);
      cyc(22, 44); cyc(22, 44); cyc(22, 44);
      chk("clear_prio", 32'(pixel_addr), 129);
      cyc(0, 0, 1'b1, 0, 1);
      cyc(0, 0, 1'b1, 1, 2);
      cyc(0, 0, 1'b1, 2, 3);
      idle(2);

      // write slot 1 while stage 1 reads it: old code now, new code next pixel
      cyc(38, 44);
      cyc(38, 44, 1'b1, 1, 9);
      cyc(38, 44);
      chk("wr_during_rd_old", 32'(pixel_addr), 145);
      cyc(38, 44);
      chk("wr_during_rd_new", 32'(pixel_addr), 649);
      cyc(0, 0, 1'b1, 1, 2);
      idle(2);

      // blink: 2 ticks hide, 2 more restore
      n_blink = 1;
      idle(3);
      cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
      cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
      cyc(38, 44); cyc(38, 44); cyc(38, 44);
      chk("blink_hidden_valid", 32'(addr_valid), 0);
      chk("blink_hidden_addr", 32'(pixel_addr), 0);
      cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
      cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
      cyc(38, 44); cyc(38, 44); cyc(38, 44);
      chk("blink_shown", 32'(pixel_addr), 145);

      // str_len=0 draws nothing
      n_len = 0;
      cyc(22, 44); cyc(22, 44); cyc(22, 44);
      chk("len0_valid", 32'(addr_valid), 0);
      n_len = 3;
      idle(2);

      // randomized sweep: geometry, writes, clears and ticks every cycle
      for (int k = 0; k < 600; k++) begin
         int h, v, wi, wc;
         bit we, clr, tk;
         if (k % 50 == 0) begin
            n_posh = int'($urandom_range(5, 100));
            n_posv = int'($urandom_range(5, 100));
         end
         n_scale = int'($urandom_range(0, 3));
         n_len   = int'($urandom_range(0, 31));
         h   = 2 * n_posh - 10 + int'($urandom_range(0, 300));
         v   = 2 * n_posv - 6 + int'($urandom_range(0, 80));
         we  = ($urandom_range(0, 7) == 0);
         wi  = int'($urandom_range(0, 15));
         wc  = int'($urandom_range(0, 63));
         clr = ($urandom_range(0, 63) == 0);
         tk  = ($urandom_range(0, 5) == 0);
         cyc(h, v, we, wi, wc, clr, tk);
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
